reg_scoreboard: RTL and testbench

Parametrised register scoreboard for the 16-bit pipelined core. It tracks every in-flight register write between ID and WB and produces per-register forwarding/stall codes plus a global load-use stall. It replaces the externally supplied 3-bit register-invalid vector the decode controller consumes, and generalises register count, pipeline depth, load latency and source-port count.

---
 rtl/reg_scoreboard.sv | 109 ++++++++++
 tb/tb_reg_scoreboard.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks in-flight register writes from EX to WB and produces
// per-register forwarding codes and the load-use stall. Define REG_SCOREBOARD_STATS_EN for stall_count.
module reg_scoreboard #(
   parameter int NREG      = 8,
   parameter int ADRW      = 3,
   parameter int DEPTH     = 3,
   parameter int LOAD_SLOT = 1,
   parameter int NSRC      = 2,
   localparam int SW       = $clog2(DEPTH + 2)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 issue_valid,
   input  logic [ADRW-1:0]      issue_adr,
   input  logic                 issue_load,
   input  logic                 flush,
   input  logic [NSRC*ADRW-1:0] src_adr,
   input  logic [NSRC-1:0]      src_use,
   input  logic [NSRC-1:0]      src_commit,
   output logic [NREG*SW-1:0]   status,
   output logic [NSRC*SW-1:0]   src_fwd,
   output logic [NREG-1:0]      pending,
   output logic                 stall
`ifdef REG_SCOREBOARD_STATS_EN
   ,
   output logic [31:0]          stall_count
`endif
);

   logic [DEPTH-1:0]           valid_q, valid_d;
   logic [DEPTH-1:0][ADRW-1:0] adr_q, adr_d;
   logic [DEPTH-1:0]           load_q, load_d;
   logic [SW-1:0]              code [NREG];
   logic                       hazard;

   // Scan oldest to youngest so the lowest-index matching slot overwrites last.
   always_comb begin
      status  = '0;
      pending = '0;
      for (int unsigned r = 0; r < NREG; r++) begin
         code[r] = '0;
         for (int unsigned j = 0; j < DEPTH; j++) begin
            if (valid_q[DEPTH-1-j] && (32'(adr_q[DEPTH-1-j]) == r)) begin
               pending[r] = 1'b1;
               if (load_q[DEPTH-1-j] && ((DEPTH - 1 - j) < LOAD_SLOT))
                  code[r] = SW'(1);
               else
                  code[r] = SW'(DEPTH + 1 - j);
            end
         end
         status[r*SW +: SW] = code[r];
      end
   end

   always_comb begin
      hazard  = 1'b0;
      src_fwd = '0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (32'(src_adr[i*ADRW +: ADRW]) < NREG)
            src_fwd[i*SW +: SW] = code[src_adr[i*ADRW +: ADRW]];
         if (src_use[i] && (src_fwd[i*SW +: SW] == SW'(1)))
            hazard = 1'b1;
         if (src_commit[i] && (src_fwd[i*SW +: SW] != '0))
            hazard = 1'b1;
      end
      stall = hazard & ~flush;
   end

   // Flush empties slots 0..DEPTH-2; the entry moving into WB is already committed.
   always_comb begin
      valid_d = {valid_q[DEPTH-2:0], issue_valid & ~stall & ~flush};
      adr_d   = {adr_q[DEPTH-2:0], issue_adr};
      load_d  = {load_q[DEPTH-2:0], issue_load};
      if (flush)
         valid_d[DEPTH-2:0] = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         adr_q   <= '0;
         load_q  <= '0;
      end else begin
         valid_q <= valid_d;
         adr_q   <= adr_d;
         load_q  <= load_d;
      end
   end

`ifdef REG_SCOREBOARD_STATS_EN
   logic [31:0] stall_count_q, stall_count_d;

   always_comb begin
      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != '1))
         stall_count_d = stall_count_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         stall_count_q <= '0;
      else
         stall_count_q <= stall_count_d;
   end

   assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus randomized
// traffic against an in-flight-instruction list model.
module tb_reg_scoreboard;

   localparam int NREG      = 8;
   localparam int ADRW      = 3;
   localparam int DEPTH     = 3;
   localparam int LOAD_SLOT = 1;
   localparam int NSRC      = 2;
   localparam int SW        = $clog2(DEPTH + 2);
   localparam int SAW       = NSRC * ADRW;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 issue_valid;
   logic [ADRW-1:0]      issue_adr;
   logic                 issue_load;
   logic                 flush;
   logic [SAW-1:0]       src_adr;
   logic [NSRC-1:0]      src_use;
   logic [NSRC-1:0]      src_commit;
   logic [NREG*SW-1:0]   status;
   logic [NSRC*SW-1:0]   src_fwd;
   logic [NREG-1:0]      pending;
   logic                 stall;
`ifdef REG_SCOREBOARD_STATS_EN
   logic [31:0]          stall_count;
`endif

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      int adr;
      bit load;
      int k;
   } ent_t;
   ent_t mq[$];
   logic [31:0] m_cnt;

   reg_scoreboard #(
      .NREG(NREG), .ADRW(ADRW), .DEPTH(DEPTH), .LOAD_SLOT(LOAD_SLOT), .NSRC(NSRC)
   ) dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_adr(issue_adr), .issue_load(issue_load),
      .flush(flush), .src_adr(src_adr), .src_use(src_use), .src_commit(src_commit),
      .status(status), .src_fwd(src_fwd), .pending(pending), .stall(stall)
`ifdef REG_SCOREBOARD_STATS_EN
      , .stall_count(stall_count)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, got running, required finished");
      $fatal(1);
   end

   function automatic logic [SW-1:0] st(int r);
      return status[r*SW +: SW];
   endfunction

   task automatic idle();
      issue_valid = 1'b0; issue_adr = '0; issue_load = 1'b0; flush = 1'b0;
      src_adr = '0; src_use = '0; src_commit = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: list of in-flight writes, each tagged with the slot it occupies.
   function automatic int m_code(int r);
      int best = -1;
      bit ld = 1'b0;
      foreach (mq[j])
         if (mq[j].adr == r && (best < 0 || mq[j].k < best)) begin
            best = mq[j].k;
            ld   = mq[j].load;
         end
      if (best < 0) return 0;
      if (ld && best < LOAD_SLOT) return 1;
      return 2 + best;
   endfunction

   task automatic m_advance(bit st_exp);
      ent_t nq[$];
      ent_t e;
      foreach (mq[j]) begin
         e = mq[j];
         e.k++;
         if (e.k >= DEPTH) continue;
         if (flush && e.k <= DEPTH - 2) continue;
         nq.push_back(e);
      end
      if (issue_valid && !st_exp && !flush) begin
         e.adr = int'(issue_adr); e.load = issue_load; e.k = 0;
         nq.push_back(e);
      end
      mq = nq;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if (status !== '0) begin n_err++; $display("FAIL reset_status: got %h, required 0", status); end
         n_cmp++; if (pending !== '0) begin n_err++; $display("FAIL reset_pending: got %h, required 0", pending); end
         n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b, required 0", stall); end
`ifdef REG_SCOREBOARD_STATS_EN
         n_cmp++; if (stall_count !== 32'd0) begin n_err++; $display("FAIL reset_count: got %0d, required 0", stall_count); end
`endif
         tick();
      end
   endtask

   task automatic test_add();
      logic [SW-1:0] exp_c [5] = '{0, 2, 3, 4, 0};
      idle();
      issue_valid = 1'b1; issue_adr = 3'd3;
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL add_stall: got %b, required 0", stall); end
      tick();
      idle();
      for (int c = 1; c <= 4; c++) begin
         n_cmp++; if (st(3) !== exp_c[c]) begin n_err++; $display("FAIL add_status3 c%0d: got %0d, required %0d", c, st(3), exp_c[c]); end
         n_cmp++; if (pending !== ((c < 4) ? 8'h08 : 8'h00)) begin n_err++; $display("FAIL add_pending c%0d: got %h", c, pending); end
         tick();
      end
   endtask

   task automatic test_load_use();
      idle();
      issue_valid = 1'b1; issue_adr = 3'd2; issue_load = 1'b1;
      tick();
      issue_adr = 3'd4; issue_load = 1'b0;
      src_adr = SAW'(2); src_use = 2'b01;
      #1;
      n_cmp++; if (st(2) !== 3'd1) begin n_err++; $display("FAIL ld_status2: got %0d, required 1", st(2)); end
      n_cmp++; if (src_fwd[0 +: SW] !== 3'd1) begin n_err++; $display("FAIL ld_fwd0: got %0d, required 1", src_fwd[0 +: SW]); end
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL ld_stall: got %b, required 1", stall); end
      tick();
      n_cmp++; if (src_fwd[0 +: SW] !== 3'd3) begin n_err++; $display("FAIL ld_fwd0_after: got %0d, required 3", src_fwd[0 +: SW]); end
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL ld_stall_after: got %b, required 0", stall); end
      n_cmp++; if (pending !== 8'h04) begin n_err++; $display("FAIL ld_bubble: got pending %h, required 04", pending); end
`ifdef REG_SCOREBOARD_STATS_EN
      n_cmp++; if (stall_count !== 32'd1) begin n_err++; $display("FAIL ld_count: got %0d, required 1", stall_count); end
`endif
      tick();
      idle();
      #1;
      n_cmp++; if (pending !== 8'h14) begin n_err++; $display("FAIL ld_consumer_pending: got %h, required 14", pending); end
      n_cmp++; if (st(4) !== 3'd2 || st(2) !== 3'd4) begin n_err++; $display("FAIL ld_codes: got r4=%0d r2=%0d, required 2 4", st(4), st(2)); end
      repeat (4) tick();
   endtask

   task automatic test_commit();
      idle();
      issue_valid = 1'b1; issue_adr = 3'd5;
      tick();
      idle();
      src_adr = SAW'(5 << ADRW); src_commit = 2'b10;
      for (int c = 1; c <= 4; c++) begin
         #1;
         n_cmp++; if (st(5) !== ((c < 4) ? SW'(c + 1) : SW'(0))) begin n_err++; $display("FAIL out_status5 c%0d: got %0d", c, st(5)); end
         n_cmp++; if (stall !== (c < 4)) begin n_err++; $display("FAIL out_stall c%0d: got %b, required %b", c, stall, c < 4); end
         tick();
      end
`ifdef REG_SCOREBOARD_STATS_EN
      n_cmp++; if (stall_count !== 32'd4) begin n_err++; $display("FAIL out_count: got %0d, required 4", stall_count); end
`endif
      idle();
      tick();
   endtask

   task automatic test_flush();
      idle();
      issue_valid = 1'b1; issue_adr = 3'd1;
      tick(); tick();
      issue_adr = 3'd6; flush = 1'b1;
      #1;
      n_cmp++; if (stall !== 1'b0 || st(1) !== 3'd2) begin n_err++; $display("FAIL fl_pre: got stall %b r1 %0d, required 0 2", stall, st(1)); end
      tick();
      idle();
      n_cmp++; if (st(1) !== 3'd4 || pending !== 8'h02) begin n_err++; $display("FAIL fl_c3: got r1 %0d pending %h, required 4 02", st(1), pending); end
      tick();
      n_cmp++; if (st(1) !== 3'd0 || pending !== 8'h00) begin n_err++; $display("FAIL fl_c4: got r1 %0d pending %h, required 0 00", st(1), pending); end
      tick();
   endtask

   task automatic test_reset_mid();
      idle();
      issue_valid = 1'b1;
      issue_adr = 3'd1; tick();
      issue_adr = 3'd2; tick();
      issue_adr = 3'd3; tick();
      issue_adr = 3'd7; src_adr = SAW'(1); src_commit = 2'b01;
      #1;
      n_cmp++; if (stall !== 1'b1 || pending !== 8'h0E) begin n_err++; $display("FAIL rm_pre: got stall %b pending %h, required 1 0E", stall, pending); end
      reset = 1'b1;
      tick();
      n_cmp++; if (status !== '0 || pending !== '0) begin n_err++; $display("FAIL rm_state: got status %h pending %h, required 0", status, pending); end
      n_cmp++; if (src_fwd !== '0 || stall !== 1'b0) begin n_err++; $display("FAIL rm_outs: got fwd %h stall %b, required 0", src_fwd, stall); end
`ifdef REG_SCOREBOARD_STATS_EN
      n_cmp++; if (stall_count !== 32'd0) begin n_err++; $display("FAIL rm_count: got %0d, required 0", stall_count); end
`endif
      reset = 1'b0;
      idle();
      tick();
   endtask

   task automatic test_random();
      logic [NREG*SW-1:0] es;
      logic [NSRC*SW-1:0] ef;
      logic [NREG-1:0]    ep;
      logic               est;
      int                 a, cd;
      idle();
      reset = 1'b1; tick(); reset = 1'b0;
      mq.delete();
      m_cnt = '0;
      for (int n = 0; n < 400; n++) begin
         issue_valid = 1'($urandom_range(0, 1));
         issue_adr   = ADRW'($urandom_range(0, NREG - 1));
         issue_load  = ($urandom_range(0, 9) < 3);
         flush       = ($urandom_range(0, 9) == 0);
         src_adr     = SAW'($urandom);
         src_use     = NSRC'($urandom);
         for (int i = 0; i < NSRC; i++) src_commit[i] = ($urandom_range(0, 19) < 3);
         #1;
         es = '0; ep = '0; ef = '0; est = 1'b0;
         for (int r = 0; r < NREG; r++) begin
            cd = m_code(r);
            es[r*SW +: SW] = SW'(cd);
            ep[r] = (cd != 0);
         end
         for (int i = 0; i < NSRC; i++) begin
            a  = int'(src_adr[i*ADRW +: ADRW]);
            cd = (a < NREG) ? m_code(a) : 0;
            ef[i*SW +: SW] = SW'(cd);
            if ((src_use[i] && cd == 1) || (src_commit[i] && cd != 0)) est = 1'b1;
         end
         est = est & !flush;
         n_cmp++; if (status !== es) begin n_err++; $display("FAIL rnd_status n%0d: got %h, required %h", n, status, es); end
         n_cmp++; if (pending !== ep) begin n_err++; $display("FAIL rnd_pending n%0d: got %h, required %h", n, pending, ep); end
         n_cmp++; if (src_fwd !== ef) begin n_err++; $display("FAIL rnd_fwd n%0d: got %h, required %h", n, src_fwd, ef); end
         n_cmp++; if (stall !== est) begin n_err++; $display("FAIL rnd_stall n%0d: got %b, required %b", n, stall, est); end
`ifdef REG_SCOREBOARD_STATS_EN
         n_cmp++; if (stall_count !== m_cnt) begin n_err++; $display("FAIL rnd_count n%0d: got %0d, required %0d", n, stall_count, m_cnt); end
`endif
         @(posedge clk);
         m_advance(est);
         if (est && m_cnt != '1) m_cnt = m_cnt + 32'd1;
         #1;
      end
      idle();
   endtask

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_add();
      test_load_use();
      test_commit();
      test_flush();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
